serial_adder_ctrl: RTL and testbench

Bit-serial addition controller that sequences a single `full_adder` instance over two WIDTH-bit operands, one bit per clock, LSB first. A stored carry flip-flop closes the loop between the adder's carry-out and carry-in. The block accepts operands with a valid/ready handshake, runs WIDTH cycles, and presents the sum, carry-out and signed overflow with a valid/ready handshake. It is the area-minimal adder path: one full adder shared across all bit positions in time.

---
 rtl/serial_adder_ctrl.sv | 158 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder that reuses one full adder over WIDTH
// clock cycles, LSB first. The carry flip-flop feeds each cycle's carry-out
// back in as the next cycle's carry-in. Operands come in and results go out
// through valid/ready handshakes.

// Single-bit full adder; the only arithmetic element in the datapath.
module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_cin,
  output logic o_sum,
  output logic o_cout
);

  assign o_sum  = i_a ^ i_b ^ i_cin;
  assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_overflow,
  output logic             o_busy
);

  // The bit counter only has to reach WIDTH-1 because the last step leaves RUN.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_sum_sr;
  logic [CW-1:0]    r_count;
  logic             r_carry;
  logic             r_prev_carry;

  logic w_fa_sum;
  logic w_fa_carry;
  logic w_accept;
  logic w_step;
  logic w_last;

  // The single shared adder always works on the current LSBs and the stored carry.
  full_adder u_fa (
    .i_a   (r_opa[0]),
    .i_b   (r_opb[0]),
    .i_cin (r_carry),
    .o_sum (w_fa_sum),
    .o_cout(w_fa_carry)
  );

  // flush stops both the accept and the bit steps, so an aborted operation
  // leaves no new datapath state behind.
  assign w_accept = (r_state == S_IDLE) && i_in_valid && !i_flush;
  assign w_step   = (r_state == S_RUN) && !i_flush;
  assign w_last   = w_step && (r_count == LAST_BIT);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and handshake decode. flush overrides every transition.
  always_comb begin
    w_next_state = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    o_busy       = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (w_accept) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        o_busy = 1'b1;
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
    if (i_flush) begin
      w_next_state = S_IDLE;
    end
  end

  // Serial datapath: load on accept, then shift one bit per RUN cycle.
  // The sum enters at the MSB, so after WIDTH steps it is aligned.
  // The counter holds at WIDTH-1 on the final step instead of wrapping.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_opa        <= '0;
      r_opb        <= '0;
      r_sum_sr     <= '0;
      r_count      <= '0;
      r_carry      <= 1'b0;
      r_prev_carry <= 1'b0;
    end else if (w_accept) begin
      r_opa    <= i_a;
      r_opb    <= i_b;
      r_sum_sr <= '0;
      r_count  <= '0;
      r_carry  <= i_cin;
    end else if (w_step) begin
      r_opa    <= {1'b0, r_opa[WIDTH-1:1]};
      r_opb    <= {1'b0, r_opb[WIDTH-1:1]};
      r_sum_sr <= {w_fa_sum, r_sum_sr[WIDTH-1:1]};
      r_carry  <= w_fa_carry;
      if (w_last) begin
        r_prev_carry <= r_carry;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Signed overflow is the carry into the MSB differing from the carry out of it.
  assign o_sum      = r_sum_sr;
  assign o_cout     = r_carry;
  assign o_overflow = r_prev_carry ^ r_carry;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: drives three serial adders (WIDTH 2, 8 and 16) and
// compares them with an arithmetic reference model of a+b+cin.
module tb_serial_adder_ctrl;

  typedef struct packed {
    logic        inReady;
    logic        outValid;
    logic        busy;
    logic        cout;
    logic        ovf;
    logic [63:0] sum;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        inValid  [3];
  logic        outReady [3];
  logic        cin      [3];
  logic [63:0] opA      [3];
  logic [63:0] opB      [3];

  logic        inReady2, outValid2, busy2, cout2, ovf2;
  logic [1:0]  sum2;
  logic        inReady8, outValid8, busy8, cout8, ovf8;
  logic [7:0]  sum8;
  logic        inReady16, outValid16, busy16, cout16, ovf16;
  logic [15:0] sum16;

  int  widths [3] = '{2, 8, 16};
  int  assertCount = 0;
  int  failCount = 0;
  time lastAccept = 0;

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(inValid[0]), .o_in_ready(inReady2),
    .i_a(opA[0][1:0]), .i_b(opB[0][1:0]), .i_cin(cin[0]), .i_flush(flush),
    .o_out_valid(outValid2), .i_out_ready(outReady[0]), .o_sum(sum2),
    .o_cout(cout2), .o_overflow(ovf2), .o_busy(busy2)
  );

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(inValid[1]), .o_in_ready(inReady8),
    .i_a(opA[1][7:0]), .i_b(opB[1][7:0]), .i_cin(cin[1]), .i_flush(flush),
    .o_out_valid(outValid8), .i_out_ready(outReady[1]), .o_sum(sum8),
    .o_cout(cout8), .o_overflow(ovf8), .o_busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(16)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_valid(inValid[2]), .o_in_ready(inReady16),
    .i_a(opA[2][15:0]), .i_b(opB[2][15:0]), .i_cin(cin[2]), .i_flush(flush),
    .o_out_valid(outValid16), .i_out_ready(outReady[2]), .o_sum(sum16),
    .o_cout(cout16), .o_overflow(ovf16), .o_busy(busy16)
  );

  // Free-running clock.
  initial forever #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic obs_t observe(int s);
    obs_t o;
    case (s)
      0:       o = '{inReady2, outValid2, busy2, cout2, ovf2, 64'(sum2)};
      1:       o = '{inReady8, outValid8, busy8, cout8, ovf8, 64'(sum8)};
      default: o = '{inReady16, outValid16, busy16, cout16, ovf16, 64'(sum16)};
    endcase
    return o;
  endfunction

  // Reference: plain integer addition, signed overflow from operand/result signs.
  task automatic model(input int w, input logic [63:0] a, input logic [63:0] b, input logic c,
                       output logic [63:0] eSum, output logic eCout, output logic eOvf);
    logic [64:0] mask;
    logic [64:0] full;
    logic        sa, sb, ss;
    mask  = (65'd1 << w) - 65'd1;
    full  = (65'(a) & mask) + (65'(b) & mask) + 65'(c);
    eSum  = 64'(full & mask);
    eCout = full[w];
    sa    = a[w-1];
    sb    = b[w-1];
    ss    = eSum[w-1];
    eOvf  = (sa == sb) && (ss != sa);
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResult(input int s, input logic [63:0] eSum, input logic eCout, input logic eOvf);
    obs_t o;
    o = observe(s);
    checkOutput("sum", o.sum, eSum);
    checkOutput("cout", 64'(o.cout), 64'(eCout));
    checkOutput("overflow", 64'(o.ovf), 64'(eOvf));
  endtask

  // Present one operand set and return 1 time unit after the accepting edge.
  task automatic applyStimulus(input int s, input logic [63:0] a, input logic [63:0] b, input logic c);
    obs_t o;
    int   n;
    n = 0;
    o = observe(s);
    while (!o.inReady && n < 50) begin
      tick();
      n++;
      o = observe(s);
    end
    if (!o.inReady) checkOutput("inReadyTimeout", 64'(0), 64'(1));
    opA[s]     = a;
    opB[s]     = b;
    cin[s]     = c;
    inValid[s] = 1'b1;
    @(posedge clk);
    lastAccept = $time;
    #1;
    inValid[s] = 1'b0;
    o = observe(s);
    checkOutput("busyAfterAccept", 64'(o.busy), 64'(1));
  endtask

  // Count cycles after the accept until out_valid rises (bounded).
  task automatic waitOutValid(input int s, input bit randReady, output int lat, output bit ok);
    obs_t o;
    lat = 0;
    ok  = 1'b0;
    while (!ok && lat < 4 * widths[s] + 10) begin
      if (randReady) outReady[s] = 1'($urandom_range(0, 1));
      tick();
      lat++;
      o = observe(s);
      if (o.outValid) ok = 1'b1;
    end
    if (!ok) checkOutput("outValidTimeout", 64'(0), 64'(1));
  endtask

  // Full operation: accept, latency, result, optional backpressure, handshake.
  task automatic runOp(input int s, input logic [63:0] a, input logic [63:0] b, input logic c,
                       input bit randReady);
    logic [63:0] eSum;
    logic        eCout, eOvf;
    int          lat, hold;
    bit          ok;
    obs_t        o;
    model(widths[s], a, b, c, eSum, eCout, eOvf);
    if (!randReady) outReady[s] = 1'b1;
    applyStimulus(s, a, b, c);
    waitOutValid(s, randReady, lat, ok);
    if (!ok) return;
    checkOutput("latency", 64'(lat), 64'(widths[s]));
    checkResult(s, eSum, eCout, eOvf);
    hold = 0;
    while (outReady[s] == 1'b0 && hold < 8) begin
      tick();
      hold++;
      o = observe(s);
      checkOutput("holdValid", 64'(o.outValid), 64'(1));
      checkResult(s, eSum, eCout, eOvf);
      outReady[s] = 1'($urandom_range(0, 1));
    end
    outReady[s] = 1'b1;
    tick();
    o = observe(s);
    checkOutput("afterHandshakeValid", 64'(o.outValid), 64'(0));
    checkOutput("afterHandshakeInReady", 64'(o.inReady), 64'(1));
    if (randReady) outReady[s] = 1'b0;
  endtask

  // Main sequence.
  initial begin
    obs_t        o;
    time         t1;
    int          lat;
    bit          ok, sawValid;
    logic [63:0] eSum;
    logic        eCout, eOvf;

    rst_n = 1'b1;
    flush = 1'b0;
    for (int s = 0; s < 3; s++) begin
      inValid[s]  = 1'b0;
      outReady[s] = 1'b0;
      cin[s]      = 1'b0;
      opA[s]      = '0;
      opB[s]      = '0;
    end
    #2 rst_n = 1'b0;
    repeat (3) tick();

    // Reset values on every width.
    for (int s = 0; s < 3; s++) begin
      o = observe(s);
      checkOutput("rstInReady", 64'(o.inReady), 64'(1));
      checkOutput("rstOutValid", 64'(o.outValid), 64'(0));
      checkOutput("rstBusy", 64'(o.busy), 64'(0));
      checkResult(s, 64'(0), 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    tick();

    $display("[TB] WIDTH=8 directed operations");
    runOp(1, 64'h5A, 64'h33, 1'b0, 1'b0);
    runOp(1, 64'hFF, 64'h01, 1'b0, 1'b0);
    t1 = lastAccept;
    runOp(1, 64'h7F, 64'h00, 1'b1, 1'b0);
    checkOutput("throughput", 64'((lastAccept - t1) / 10), 64'(8 + 2));
    outReady[1] = 1'b0;

    $display("[TB] WIDTH=8 backpressure");
    model(8, 64'h5A, 64'h33, 1'b0, eSum, eCout, eOvf);
    applyStimulus(1, 64'h5A, 64'h33, 1'b0);
    waitOutValid(1, 1'b0, lat, ok);
    opA[1] = 64'h11;
    opB[1] = 64'h22;
    cin[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      inValid[1] = 1'b1;
      tick();
      o = observe(1);
      checkOutput("bpValid", 64'(o.outValid), 64'(1));
      checkOutput("bpInReady", 64'(o.inReady), 64'(0));
      checkResult(1, eSum, eCout, eOvf);
    end
    inValid[1]  = 1'b0;
    outReady[1] = 1'b1;
    tick();
    o = observe(1);
    checkOutput("bpReleaseInReady", 64'(o.inReady), 64'(1));
    checkOutput("bpReleaseValid", 64'(o.outValid), 64'(0));
    runOp(1, 64'h11, 64'h22, 1'b0, 1'b0);
    outReady[1] = 1'b0;

    $display("[TB] WIDTH=8 flush");
    applyStimulus(1, 64'hAA, 64'h55, 1'b1);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    o = observe(1);
    checkOutput("flushInReady", 64'(o.inReady), 64'(1));
    checkOutput("flushBusy", 64'(o.busy), 64'(0));
    sawValid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      o = observe(1);
      if (o.outValid) sawValid = 1'b1;
    end
    checkOutput("noValidAfterFlush", 64'(sawValid), 64'(0));
    opA[1]     = 64'h01;
    opB[1]     = 64'h02;
    inValid[1] = 1'b1;
    flush      = 1'b1;
    tick();
    inValid[1] = 1'b0;
    flush      = 1'b0;
    o = observe(1);
    checkOutput("flushBlocksAccept", 64'(o.busy), 64'(0));
    runOp(1, 64'h10, 64'h20, 1'b0, 1'b0);
    outReady[1] = 1'b0;

    $display("[TB] WIDTH=8 reset mid-run");
    applyStimulus(1, 64'hC3, 64'h3C, 1'b0);
    repeat (2) tick();
    #2;
    rst_n = 1'b0;
    #1;
    o = observe(1);
    checkOutput("midRstInReady", 64'(o.inReady), 64'(1));
    checkOutput("midRstBusy", 64'(o.busy), 64'(0));
    checkOutput("midRstValid", 64'(o.outValid), 64'(0));
    checkResult(1, 64'(0), 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    runOp(1, 64'hC3, 64'h3C, 1'b0, 1'b0);
    outReady[1] = 1'b0;

    $display("[TB] WIDTH=2 exhaustive");
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++)
          runOp(0, 64'(a), 64'(b), 1'(c), 1'b1);

    $display("[TB] WIDTH=16 random");
    for (int i = 0; i < 1000; i++)
      runOp(2, 64'($urandom_range(0, 65535)), 64'($urandom_range(0, 65535)),
            1'($urandom_range(0, 1)), 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
